muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO registers, the next-generation execute-stage extension of the pipelined MIPS core. It adds MULT, MULTU, DIV and DIVU plus MTHI and MTLO, which the current datapath lacks. It sits beside the ALU in EX and is started by the ID/EX stage. It reports `busy` so the hazard detection unit stalls any MFHI or MFLO, and any new mult/div, until the result is committed.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_unit_if.sv | 33 +++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   OP_*    : encoding of the 2-bit op field supplied by the control decoder
//   state_t : sequencer states
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Bus between the ID/EX stage (master) and the multiply/divide unit (slave).
//   start/op/a/b    : launch request and operands
//   cancel          : pipeline flush
//   hi_we/lo_we     : MTHI/MTLO strobes with shared wdata
//   busy/done       : status for the hazard unit and commit pulse
//   div_zero/hi/lo  : sticky divide-by-zero flag and architectural HI/LO
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  cancel;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per RUN cycle (DATA_WIDTH cycles), sign fix-up in FIX,
// HI/LO committed on the FIX->DONE edge.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : muldiv_unit_if slave (start/op/a/b/cancel/hi_we/lo_we/wdata in,
//           busy/done/div_zero/hi/lo out)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  state_t          state;
  logic [1:0]      op_q;
  logic            sign_a;
  logic            sign_b;
  logic [W-1:0]    mcand;     // multiplicand magnitude or divisor magnitude
  logic [2*W-1:0]  acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]   cnt;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic            busy_q;
  logic            done_q;
  logic            dz_q;

  logic            is_div;
  logic            is_signed;
  logic            in_signed;
  logic [W-1:0]    mag_a_in;
  logic [W-1:0]    mag_b_in;

  logic [W:0]      add_x;
  logic [W:0]      add_y;
  logic            add_c;
  logic [W:0]      add_s;
  logic [2*W-1:0]  acc_next;

  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    res_hi;
  logic [W-1:0]    res_lo;
  logic            div_by_zero;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign mag_a_in  = (in_signed && bus.a[W-1]) ? -bus.a : bus.a;
  assign mag_b_in  = (in_signed && bus.b[W-1]) ? -bus.b : bus.b;
  assign div_by_zero = is_div && (mcand == '0);

  // Single W+1-bit adder: add-multiplicand for multiply, subtract-divisor
  // (two's complement) for the restoring divide trial.
  always_comb begin
    add_x = '0;
    add_y = '0;
    add_c = 1'b0;
    if (is_div) begin
      add_x = {acc[2*W-1:W], acc[W-1]};
      add_y = ~{1'b0, mcand};
      add_c = 1'b1;
    end else begin
      add_x = {1'b0, acc[2*W-1:W]};
      add_y = acc[0] ? {1'b0, mcand} : '0;
      add_c = 1'b0;
    end
    add_s = add_x + add_y + {{W{1'b0}}, add_c};
  end

  // Divide: shifted remainder is always < 2*divisor, so bit W of the trial
  // difference is set exactly when the subtraction borrows.
  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (add_s[W]) acc_next = {acc[2*W-2:0], 1'b0};
      else          acc_next = {add_s[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      acc_next = {add_s, acc[W-1:1]};
    end
  end

  // Divide-by-zero needs only the LO override: the restoring loop leaves
  // |a| in the remainder, and the dividend-sign fix-up restores a itself.
  // MIN/-1 falls out of the normal fix-up without a special case.
  always_comb begin
    prod_fix = acc;
    res_hi   = '0;
    res_lo   = '0;
    if (is_div) begin
      res_lo = (is_signed && (sign_a ^ sign_b)) ? -acc[W-1:0] : acc[W-1:0];
      res_hi = (is_signed && sign_a) ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (div_by_zero) res_lo = '1;
    end else begin
      if (is_signed && (sign_a ^ sign_b)) prod_fix = -acc;
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
    end else if (bus.cancel && (state != IDLE)) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            dz_q   <= 1'b0;
            op_q   <= bus.op;
            sign_a <= bus.a[W-1];
            sign_b <= bus.b[W-1];
            mcand  <= mag_b_in;
            acc    <= {{W{1'b0}}, mag_a_in};
            cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          dz_q   <= div_by_zero;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (W=32): vector table, random vectors
// against a behavioural model, and hand-written control-input sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;
  int   busy_cnt = 0;
  exp_t sbq[$];
  vec_t vecs[10];

  muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    edge_no++;
    if (bus.busy) busy_cnt++;
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          sa;
    int          sb;
    longint      pa;
    longint      pb;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      OP_MULT: begin
        pa = sa; pb = sb; ps = pa * pb;
        e.hi = ps[63:32]; e.lo = ps[31:0];
      end
      OP_MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (op == OP_DIV) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = a; e.hi = '0;
          end else begin
            e.lo = sa / sb; e.hi = sa % sb;
          end
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    edge_no   = -1;
    busy_cnt  = 0;
    tick();
    if (!hold) bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("dz_cleared_on_start", bus.div_zero, 0);
  endtask

  task automatic wait_done(input string name, input int exp_edge);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < W + 8 && !got; i++) begin
      tick();
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=no_done required=done_at_edge_%0d", name, exp_edge);
    end else begin
      chk({name, "_done_edge"}, edge_no, exp_edge);
      chk({name, "_busy_cycles"}, busy_cnt, W + 1);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_scoreboard actual=empty required=entry", name);
      end else begin
        e = sbq.pop_front();
        chk({name, "_hi"}, bus.hi, e.hi);
        chk({name, "_lo"}, bus.lo, e.lo);
        chk({name, "_dz"}, bus.div_zero, e.dz);
      end
    end
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
    sbq.push_back(e);
    launch(op, a, b, 1'b0);
    wait_done(name, W + 1);
    tick();
    chk({name, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    exp_t e;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int n_done;
    int first_done;

    vecs[0] = '{"mult_neg",     OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{"multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{"div_neg",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{"divu_zero",    OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{"div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{"mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{"multu_shift",  OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[7] = '{"div_pos_neg",  OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{"div_neg_neg",  OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    vecs[9] = '{"div_zero_neg", OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.cancel = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_dz",   bus.div_zero, 0);
    chk("reset_hi",   bus.hi, 0);
    chk("reset_lo",   bus.lo, 0);

    // table vectors
    for (int i = 0; i < 10; i++) begin
      e.hi = vecs[i].hi;
      e.lo = vecs[i].lo;
      e.dz = vecs[i].dz;
      run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    // random vectors against the behavioural model
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_vec("rand", rop, ra, rb, model(rop, ra, rb));
    end

    // MTHI/MTLO while idle, both strobes together then LO alone
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1111_1111;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mt_both_hi", bus.hi, 32'h1111_1111);
    chk("mt_both_lo", bus.lo, 32'h1111_1111);
    bus.lo_we = 1'b1; bus.wdata = 32'h2222_2222;
    tick();
    bus.lo_we = 1'b0;
    chk("mtlo_hi_kept", bus.hi, 32'h1111_1111);
    chk("mtlo_lo",      bus.lo, 32'h2222_2222);

    // start pulsed at edge 5 of a run is ignored
    sbq.push_back(model(OP_DIVU, 32'd100, 32'd7));
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    wait_done("start_glitch", W + 1);
    tick();
    chk("start_glitch_idle_busy", bus.busy, 0);

    // hi_we while busy is dropped
    bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.hi_we = 1'b0;
    chk("mthi_idle", bus.hi, 32'hA5A5_A5A5);
    sbq.push_back(model(OP_MULTU, 32'd3, 32'd5));
    launch(OP_MULTU, 32'd3, 32'd5, 1'b0);
    repeat (2) tick();
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.hi_we = 1'b0;
    chk("hi_we_busy_dropped", bus.hi, 32'hA5A5_A5A5);
    wait_done("hi_we_busy", W + 1);
    tick();

    // start and hi_we in the same cycle: write lands now, result later
    bus.hi_we = 1'b1; bus.wdata = 32'h3333_3333;
    sbq.push_back(model(OP_DIVU, 32'd100, 32'd7));
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0);
    bus.hi_we = 1'b0;
    chk("start_with_mthi", bus.hi, 32'h3333_3333);
    wait_done("start_with_mthi", W + 1);
    tick();

    // cancel at edge 10 keeps HI/LO and produces no done
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h4444_4444;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    repeat (9) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_busy", bus.busy, 0);
    chk("cancel_hi", bus.hi, 32'h4444_4444);
    chk("cancel_lo", bus.lo, 32'h4444_4444);
    n_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("cancel_no_done", n_done, 0);
    chk("cancel_hi_later", bus.hi, 32'h4444_4444);

    // reset at edge 20 of a fresh run
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    chk("midreset_dz",   bus.div_zero, 0);
    chk("midreset_hi",   bus.hi, 0);
    chk("midreset_lo",   bus.lo, 0);
    n_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("midreset_no_done", n_done, 0);

    // start held in DONE: back-to-back done pulses W+2 cycles apart
    sbq.push_back(model(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    sbq.push_back(model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF));
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("b2b_first", W + 1);
    first_done = edge_no;
    bus.op = OP_DIV; bus.a = 32'h8000_0000; bus.b = 32'hFFFF_FFFF;
    busy_cnt = 0;
    tick();
    bus.start = 1'b0;
    chk("b2b_relaunch_busy", bus.busy, 1);
    wait_done("b2b_second", 2 * W + 3);
    chk("b2b_spacing", edge_no - first_done, W + 2);
    tick();
    chk("b2b_done_pulse", bus.done, 0);
    chk("b2b_scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
